// File: rtl/counter_window_ctrl.sv
// Wishbone-controlled measurement window for an external 16-bit event counter.
// The block opens the counter for WINDOW cycles, then captures its count and raises DONE and irq_o.
module counter_window_ctrl #(
  parameter int WIN_W   = 24,
  parameter int WIN_RST = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [15:0] cnt_count_i,
  output logic        cnt_enable_o,
  output logic        cnt_clear_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  state_e             state_q;
  logic [1:0]         rst_sync_q;
  logic               active;
  logic               ack_q, irq_q, cnt_enable_q, cnt_clear_q;
  logic [31:0]        dat_q;
  logic               cont_q, irq_en_q;
  logic [WIN_W-1:0]   window_q, window_d, down_q, win_load;
  logic [15:0]        result_q, seq_q;
  logic               done_q, overrun_q;

  logic               bus_req, bus_wr;
  logic [1:0]         reg_idx;
  logic               ctrl_wr, win_wr, stat_w1c, start_req, abort_req;
  logic [31:0]        win_merged, rdata;

  // Reset release is re-timed so nothing moves before the second edge after deassertion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign active = rst_sync_q[1];

  assign bus_req   = active & wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign bus_wr    = bus_req & wbs_we_i;
  assign reg_idx   = wbs_adr_i[3:2];
  assign ctrl_wr   = bus_wr && (reg_idx == 2'd0) && wbs_sel_i[0];
  assign win_wr    = bus_wr && (reg_idx == 2'd1);
  assign stat_w1c  = bus_wr && (reg_idx == 2'd3) && wbs_sel_i[0];
  assign start_req = ctrl_wr & wbs_dat_i[0];
  assign abort_req = ctrl_wr & wbs_dat_i[2];
  assign win_load  = (window_q == '0) ? WIN_W'(1) : window_q;

  // NOTE: every variable an always_comb writes gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_merged = 32'(window_q);
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) win_merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
    window_d = win_wr ? win_merged[WIN_W-1:0] : window_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0: rdata = {28'd0, irq_en_q, 1'b0, cont_q, 1'b0};
      2'd1: rdata = 32'(window_q);
      2'd2: rdata = {seq_q, result_q};
      2'd3: rdata = {27'd0, state_q, overrun_q, done_q, (state_q != S_IDLE)};
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      window_q <= WIN_W'(WIN_RST);
      irq_q    <= 1'b0;
    end else if (active) begin
      ack_q    <= bus_req;
      window_q <= window_d;
      irq_q    <= done_q & irq_en_q;
      if (bus_req && !wbs_we_i) dat_q <= rdata;
      if (ctrl_wr) begin
        cont_q   <= wbs_dat_i[1];
        irq_en_q <= wbs_dat_i[3];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      down_q       <= '0;
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      result_q     <= '0;
      seq_q        <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (active) begin
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      // W1C comes first so a capture in the same cycle overrides it.
      if (stat_w1c) begin
        if (wbs_dat_i[1]) done_q    <= 1'b0;
        if (wbs_dat_i[2]) overrun_q <= 1'b0;
      end
      if (abort_req && state_q != S_IDLE) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_req && !abort_req) begin
              state_q     <= S_CLEAR;
              cnt_clear_q <= 1'b1;
            end
          end
          S_CLEAR: begin
            down_q       <= win_load;
            state_q      <= S_RUN;
            cnt_enable_q <= 1'b1;
          end
          S_RUN: begin
            if (down_q == WIN_W'(1)) begin
              state_q <= S_CAPTURE;
            end else begin
              down_q       <= down_q - WIN_W'(1);
              cnt_enable_q <= 1'b1;
            end
          end
          S_CAPTURE: begin
            result_q <= cnt_count_i;
            seq_q    <= seq_q + 16'd1;
            done_q   <= 1'b1;
            if (done_q) overrun_q <= 1'b1;
            if (cont_q) begin
              state_q     <= S_CLEAR;
              cnt_clear_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign cnt_enable_o = cnt_enable_q;
  assign cnt_clear_o  = cnt_clear_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_counter_window_ctrl.sv
// Directed bench for counter_window_ctrl: register access, single/continuous windows, abort and reset.
module tb_counter_window_ctrl;

  localparam logic [31:0] A_CTRL = 32'h0, A_WIN = 32'h4, A_RES = 32'h8, A_STAT = 32'hC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, cnt_enable_o, cnt_clear_o, irq_o;
  logic [15:0] cnt_q;

  int n_checks = 0;
  int n_errors = 0;
  int en_cycles = 0;
  int clr_pulses = 0;

  always #5 clk = ~clk;

  counter_window_ctrl #(.WIN_W(24), .WIN_RST(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .cnt_count_i(cnt_q), .cnt_enable_o(cnt_enable_o), .cnt_clear_o(cnt_clear_o), .irq_o(irq_o)
  );

  // Event counter that counts every enabled cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt_q <= '0;
    else if (cnt_clear_o)  cnt_q <= '0;
    else if (cnt_enable_o) cnt_q <= cnt_q + 16'd1;
  end

  always @(posedge clk) begin
    if (cnt_enable_o) en_cycles++;
    if (cnt_clear_o)  clr_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the ack edge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    bit got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    rd = wbs_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'd0, 4'h0, rd);
  endtask

  task automatic wait_status(input int bit_idx, input logic level, input string tag);
    logic [31:0] st;
    bit ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      wb_read(A_STAT, st);
      if (st[bit_idx] == level) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_regs(input string pfx);
    logic [31:0] rd;
    wb_read(A_CTRL, rd); check({pfx, "_ctrl"}, rd, 32'h0);
    wb_read(A_WIN,  rd); check({pfx, "_window"}, rd, 32'h100);
    wb_read(A_RES,  rd); check({pfx, "_result"}, rd, 32'h0);
    wb_read(A_STAT, rd); check({pfx, "_status"}, rd, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, r_before;
    int en0, clr0, seq0, seq1;

    // Reset state
    #2;
    check("rst_outputs", {wbs_dat_o[0], wbs_ack_o, cnt_enable_o, cnt_clear_o, irq_o}, 32'h0);
    do_reset();
    check_reset_regs("rst");
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(wbs_ack_o), 32'd0);

    // Single window of 10 cycles with interrupt enabled
    wb_write(A_WIN, 32'd10, 4'hF);
    wb_read(A_WIN, rd); check("win_10", rd, 32'd10);
    check("irq_idle", 32'(irq_o), 32'd0);
    en0 = en_cycles; clr0 = clr_pulses;
    wb_write(A_CTRL, 32'h9, 4'h1);
    wait_status(0, 1'b0, "win10_timeout");
    check("win10_enable_cycles", 32'(en_cycles - en0), 32'd10);
    check("win10_clear_pulses", 32'(clr_pulses - clr0), 32'd1);
    wb_read(A_RES, rd);  check("win10_result", rd, 32'h0001_000A);
    wb_read(A_STAT, rd); check("win10_status", rd, 32'h2);
    check("win10_irq", 32'(irq_o), 32'd1);
    wb_read(A_CTRL, rd); check("ctrl_pulses_read0", rd, 32'h8);

    // W1C of DONE, then WINDOW=0 behaves as 1
    wb_write(A_STAT, 32'h2, 4'h1);
    wb_read(A_STAT, rd); check("done_w1c", rd, 32'h0);
    check("irq_cleared", 32'(irq_o), 32'd0);
    wb_write(A_WIN, 32'd0, 4'hF);
    en0 = en_cycles;
    wb_write(A_CTRL, 32'h1, 4'h1);
    wait_status(0, 1'b0, "win0_timeout");
    check("win0_enable_cycles", 32'(en_cycles - en0), 32'd1);
    wb_read(A_RES, rd); check("win0_result", rd, 32'h0002_0001);
    check("win0_irq_disabled", 32'(irq_o), 32'd0);

    // Byte lanes and read-only RESULT
    wb_write(A_WIN, 32'h00AA_BBCC, 4'b0010);
    wb_read(A_WIN, rd); check("win_byte_lane", rd, 32'h0000_BB00);
    wb_write(A_RES, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_RES, rd); check("result_readonly", rd, 32'h0002_0001);

    // Continuous mode: second capture without clearing DONE sets OVERRUN
    wb_write(A_STAT, 32'h6, 4'h1);
    wb_write(A_WIN, 32'd4, 4'hF);
    en0 = en_cycles; clr0 = clr_pulses; seq0 = 2;
    wb_write(A_CTRL, 32'h3, 4'h1);
    wait_status(2, 1'b1, "overrun_timeout");
    wb_write(A_CTRL, 32'h0, 4'h1);
    wait_status(0, 1'b0, "cont_stop_timeout");
    wb_read(A_STAT, rd); check("cont_status", rd, 32'h6);
    wb_read(A_RES, rd);
    r_before = rd;
    seq1 = int'(rd[31:16]);
    check("cont_result_cnt", 32'(rd[15:0]), 32'd4);
    check("cont_seq_at_least_2", 32'(seq1 - seq0 >= 2), 32'd1);
    check("cont_enable_cycles", 32'(en_cycles - en0), 32'(4 * (seq1 - seq0)));
    check("cont_clear_pulses", 32'(clr_pulses - clr0), 32'(seq1 - seq0));
    wb_write(A_STAT, 32'h6, 4'h1);
    wb_read(A_STAT, rd); check("cont_w1c_both", rd, 32'h0);

    // Abort after 3 RUN cycles
    wb_write(A_WIN, 32'd20, 4'hF);
    en0 = en_cycles;
    wb_write(A_CTRL, 32'h1, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    wb_write(A_CTRL, 32'h4, 4'h1);
    check("abort_enable_low", 32'(cnt_enable_o), 32'd0);
    check("abort_enable_cycles", 32'(en_cycles - en0), 32'd3);
    wb_read(A_STAT, rd); check("abort_status_idle", rd, 32'h0);
    wb_read(A_RES, rd);  check("abort_result_kept", rd, r_before);

    // START and ABORT together: ABORT wins
    en0 = en_cycles; clr0 = clr_pulses;
    wb_write(A_CTRL, 32'h5, 4'h1);
    wb_read(A_STAT, rd); check("start_abort_idle", rd, 32'h0);
    check("start_abort_no_clear", 32'(clr_pulses - clr0), 32'd0);

    // Reset mid-RUN
    wb_write(A_WIN, 32'd50, 4'hF);
    wb_write(A_CTRL, 32'hB, 4'h1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_running", 32'(cnt_enable_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, wbs_dat_o != 0, wbs_ack_o, cnt_enable_o, cnt_clear_o, irq_o}, 32'h0);
    en0 = en_cycles;
    do_reset();
    check("reset_no_enable", 32'(en_cycles - en0), 32'd0);
    check_reset_regs("midrun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_window_ctrl.md
COUNTER_WINDOW_CTRL -- requirements
Module: counter_window_ctrl

Interface
REQ-001 Parameter WIN_W, default 24, SHALL set the width of the measurement-window length register.
REQ-002 Parameter WIN_RST, default 256, SHALL be the reset value of the window length register.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  SHALL be the Wishbone classic slave strobes.
REQ-006 wbs_sel_i  input  4  SHALL be byte-lane enables for writes.
REQ-007 wbs_adr_i  input  32  SHALL be the byte address; only bits [3:2] are decoded.
REQ-008 wbs_dat_i  input  32  SHALL be write data; wbs_dat_o  output  32  SHALL be read data; wbs_ack_o  output  1  SHALL be the acknowledge.
REQ-009 cnt_count_i  input  16  SHALL be the registered count from the 16-bit event-counter datapath.
REQ-010 cnt_enable_o  output  1  SHALL gate the counter's enable.
REQ-011 cnt_clear_o  output  1  SHALL be a one-cycle synchronous clear pulse to the counter.
REQ-012 irq_o  output  1  SHALL be the registered level interrupt.

Function
REQ-013 Registers: 0x0 CTRL, 0x4 WINDOW, 0x8 RESULT (read-only), 0xC STATUS; all 32-bit, unused bits read 0.
REQ-014 CTRL: bit0 START (write-1 pulse, reads 0), bit1 CONT (continuous mode), bit2 ABORT (write-1 pulse, reads 0), bit3 IRQ_EN.
REQ-015 WINDOW[WIN_W-1:0] SHALL hold the window length in clk cycles; a value of 0 SHALL be treated as 1.
REQ-016 RESULT[15:0] SHALL hold the last captured count; RESULT[31:16] SHALL hold a capture sequence number that increments per capture and wraps 0xFFFF->0.
REQ-017 STATUS: bit0 BUSY (state != IDLE), bit1 DONE (sticky, write-1-to-clear), bit2 OVERRUN (sticky, W1C), bits[4:3] state encoding.
REQ-018 Writes SHALL honour wbs_sel_i per byte lane; writes to RESULT SHALL be ignored.
REQ-019 wbs_ack_o SHALL assert one cycle after cyc&stb is sampled high with ack low, for exactly one cycle; read data SHALL be valid with ack.
REQ-020 FSM states SHALL be IDLE(0), CLEAR(1), RUN(2), CAPTURE(3).
REQ-021 IDLE: cnt_enable_o=0; START -> CLEAR.
REQ-022 CLEAR: cnt_clear_o=1 for this one cycle; window down-counter loads max(WINDOW,1); -> RUN.
REQ-023 RUN: cnt_enable_o=1; down-counter decrements each cycle; when it equals 1 -> CAPTURE, giving exactly WINDOW enabled cycles.
REQ-024 CAPTURE: cnt_enable_o=0; RESULT[15:0] <= cnt_count_i; sequence++; DONE <= 1; if DONE was already 1, OVERRUN <= 1; -> CLEAR if CONT=1, else IDLE.
REQ-025 ABORT in any non-IDLE state SHALL force IDLE next cycle with cnt_enable_o=0, no capture, DONE/RESULT unchanged.
REQ-026 START while BUSY SHALL be ignored; START and ABORT in the same write: ABORT wins.
REQ-027 A WINDOW write while BUSY SHALL take effect at the next CLEAR only.
REQ-028 A W1C of DONE/OVERRUN coincident with CAPTURE setting them: set wins.
REQ-029 Clearing CONT while in RUN SHALL let the current window complete, then return to IDLE.
REQ-030 irq_o SHALL equal DONE & IRQ_EN, registered (one-cycle lag).

Reset
REQ-031 reset_n low SHALL immediately force IDLE, cnt_enable_o=0, cnt_clear_o=0, wbs_ack_o=0, irq_o=0, CTRL=0, WINDOW=WIN_RST, RESULT=0, DONE=OVERRUN=0, wbs_dat_o=0.
REQ-032 Reset asserted mid-window SHALL discard the window with no capture; release SHALL be synchronised so the first state change occurs no earlier than the second clk edge after deassertion.

Verification
REQ-033 Reset then read all registers -> CTRL=0, WINDOW=0x100, RESULT=0, STATUS=0.
REQ-034 WINDOW=10, counter counting every enabled cycle, START -> cnt_clear_o one pulse, cnt_enable_o high exactly 10 cycles, RESULT=0x0001_000A, DONE=1, irq_o=1 one cycle later with IRQ_EN=1.
REQ-035 WINDOW=0, START -> exactly 1 enabled cycle, RESULT[15:0]=1.
REQ-036 CONT=1, WINDOW=4, no DONE clears -> second capture sets OVERRUN, sequence=2; write 0x6 to STATUS -> DONE=OVERRUN=0.
REQ-037 START, ABORT after 3 RUN cycles -> IDLE next cycle, cnt_enable_o=0, RESULT and DONE unchanged; START+ABORT in one write -> stays IDLE.
REQ-038 reset_n pulsed low mid-RUN -> outputs zero asynchronously, no capture, registers at reset values.
